// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking spot allocator and its free-spot encoder.
package parking_pkg;

    localparam int unsigned SPOTS_DEFAULT  = 8;
    localparam int unsigned SPOT_W_DEFAULT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } gate_state_e;

    typedef struct packed {
        logic                      found;
        logic [SPOT_W_DEFAULT-1:0] index;
    } free_spot_t;

    // Lowest index whose bitmap bit is clear and whose mask bit is set.
    function automatic free_spot_t lowest_free(input logic [SPOTS_DEFAULT-1:0] bitmap,
                                               input logic [SPOTS_DEFAULT-1:0] mask);
        free_spot_t res;
        res = '0;
        for (int unsigned i = 0; i < SPOTS_DEFAULT; i++) begin
            if (!res.found && !bitmap[i] && mask[i]) begin
                res.found = 1'b1;
                res.index = i[SPOT_W_DEFAULT-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/parking_free_spot_encoder.sv
// Combinational priority encoder: lowest eligible free spot of an occupancy bitmap.
module parking_free_spot_encoder #(
    parameter int unsigned SPOTS  = 8,
    parameter int unsigned SPOT_W = 3
) (
    input  logic [SPOTS-1:0]  bitmap,
    input  logic [SPOTS-1:0]  mask,
    output logic [SPOT_W-1:0] index,
    output logic              found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < SPOTS; i++) begin
            if (!found && !bitmap[i] && mask[i]) begin
                found = 1'b1;
                index = i[SPOT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/parking_spot_allocator.sv
// Occupancy bitmap producer and entry-gate sequencer for the car park.
// Optional reserved top spot for VIP entries: define PARKING_RESERVED_SPOT_EN.
module parking_spot_allocator
    import parking_pkg::*;
#(
    parameter int unsigned SPOTS       = SPOTS_DEFAULT,
    parameter int unsigned SPOT_W      = SPOT_W_DEFAULT,
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              entry_req,
    input  logic              entry_vip,
    output logic              entry_ack,
    output logic [SPOT_W-1:0] entry_spot,
    output logic              entry_full,
    input  logic              exit_req,
    input  logic [SPOT_W-1:0] exit_spot,
    output logic              exit_ack,
    output logic              exit_err,
    output logic              gate_open,
    output logic [SPOTS-1:0]  new_capacity
);

    localparam int unsigned       CNT_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(GATE_CYCLES - 1);
    localparam logic [SPOT_W:0]   SPOTS_L  = SPOTS[SPOT_W:0];

    gate_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SPOTS-1:0]  capacity_q, capacity_d;
    logic [SPOT_W-1:0] entry_spot_q, entry_spot_d;
    logic              entry_ack_q, entry_ack_d;
    logic              entry_full_q, entry_full_d;
    logic              exit_ack_q, exit_ack_d;
    logic              exit_err_q, exit_err_d;

    logic [SPOTS-1:0]  elig_mask;
    logic [SPOT_W-1:0] free_idx;
    logic              free_found;
    logic [SPOTS-1:0]  alloc_onehot;
    logic [SPOTS-1:0]  exit_onehot;
    logic              exit_in_range;
    logic              exit_hit;

`ifdef PARKING_RESERVED_SPOT_EN
    always_comb begin
        elig_mask = '1;
        if (!entry_vip) begin
            elig_mask[SPOTS-1] = 1'b0;
        end
    end
`else
    logic unused_entry_vip;
    assign unused_entry_vip = entry_vip;
    assign elig_mask        = '1;
`endif

    // Searches the pre-exit bitmap so a spot freed this edge is not handed out again.
    parking_free_spot_encoder #(
        .SPOTS  (SPOTS),
        .SPOT_W (SPOT_W)
    ) u_encoder (
        .bitmap (capacity_q),
        .mask   (elig_mask),
        .index  (free_idx),
        .found  (free_found)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        entry_ack_d  = 1'b0;
        entry_spot_d = entry_spot_q;
        entry_full_d = 1'b0;
        alloc_onehot = '0;

        case (state_q)
            IDLE: begin
                if (entry_req) begin
                    if (free_found) begin
                        entry_ack_d  = 1'b1;
                        entry_spot_d = free_idx;
                        alloc_onehot = SPOTS'(1) << free_idx;
                        cnt_d        = CNT_LOAD;
                        state_d      = OPEN;
                    end else begin
                        entry_full_d = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exit_in_range = ({1'b0, exit_spot} < SPOTS_L);
        exit_hit      = 1'b0;
        exit_onehot   = '0;
        exit_ack_d    = 1'b0;
        exit_err_d    = 1'b0;
        if (exit_req) begin
            if (exit_in_range && capacity_q[exit_spot]) begin
                exit_hit    = 1'b1;
                exit_onehot = SPOTS'(1) << exit_spot;
                exit_ack_d  = 1'b1;
            end else begin
                exit_err_d  = 1'b1;
            end
        end
        capacity_d = (capacity_q | alloc_onehot) & ~exit_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            capacity_q   <= '0;
            entry_spot_q <= '0;
            entry_ack_q  <= 1'b0;
            entry_full_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            capacity_q   <= capacity_d;
            entry_spot_q <= entry_spot_d;
            entry_ack_q  <= entry_ack_d;
            entry_full_q <= entry_full_d;
            exit_ack_q   <= exit_ack_d;
            exit_err_q   <= exit_err_d;
        end
    end

    assign entry_ack    = entry_ack_q;
    assign entry_spot   = entry_spot_q;
    assign entry_full   = entry_full_q;
    assign exit_ack     = exit_ack_q;
    assign exit_err     = exit_err_q;
    assign gate_open    = (state_q == OPEN);
    assign new_capacity = capacity_q;

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Directed self-checking bench for parking_spot_allocator (8 spots, 4-cycle gate).
module tb_parking_spot_allocator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       entry_req;
    logic       entry_vip;
    logic       entry_ack;
    logic [2:0] entry_spot;
    logic       entry_full;
    logic       exit_req;
    logic [2:0] exit_spot;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_open;
    logic [7:0] new_capacity;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    parking_spot_allocator #(
        .SPOTS       (8),
        .SPOT_W      (3),
        .GATE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_req    (entry_req),
        .entry_vip    (entry_vip),
        .entry_ack    (entry_ack),
        .entry_spot   (entry_spot),
        .entry_full   (entry_full),
        .exit_req     (exit_req),
        .exit_spot    (exit_spot),
        .exit_ack     (exit_ack),
        .exit_err     (exit_err),
        .gate_open    (gate_open),
        .new_capacity (new_capacity)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gate stays high for 'high_left' more edges, then drops.
    task automatic gate_close(input int unsigned high_left);
        for (int unsigned i = 0; i < high_left; i++) begin
            step();
            check("gate_held", {31'd0, gate_open}, 32'd1);
        end
        step();
        check("gate_closed", {31'd0, gate_open}, 32'd0);
    endtask

    task automatic do_entry(input logic [2:0] exp_spot, input logic [7:0] exp_cap);
        entry_req = 1'b1;
        step();
        check("entry_ack", {31'd0, entry_ack}, 32'd1);
        check("entry_spot", {29'd0, entry_spot}, {29'd0, exp_spot});
        check("entry_cap", {24'd0, new_capacity}, {24'd0, exp_cap});
        entry_req = 1'b0;
        gate_close(3);
    endtask

    task automatic do_exit(input logic [2:0] spot, input logic [7:0] exp_cap);
        exit_req  = 1'b1;
        exit_spot = spot;
        step();
        check("exit_ack", {31'd0, exit_ack}, 32'd1);
        check("exit_cap", {24'd0, new_capacity}, {24'd0, exp_cap});
        exit_req  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        entry_req = 1'b0;
        entry_vip = 1'b0;
        exit_req  = 1'b0;
        exit_spot = 3'd0;
        #12;
        check("rst_cap", {24'd0, new_capacity}, 32'd0);
        check("rst_gate", {31'd0, gate_open}, 32'd0);
        check("rst_ack", {31'd0, entry_ack}, 32'd0);
        check("rst_full", {31'd0, entry_full}, 32'd0);
        check("rst_spot", {29'd0, entry_spot}, 32'd0);
        check("rst_exit", {30'd0, exit_ack, exit_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // First car: spot 0, gate high for exactly four cycles.
        entry_req = 1'b1;
        step();
        check("t1_ack", {31'd0, entry_ack}, 32'd1);
        check("t1_spot", {29'd0, entry_spot}, 32'd0);
        check("t1_cap", {24'd0, new_capacity}, 32'h01);
        check("t1_gate", {31'd0, gate_open}, 32'd1);
        entry_req = 1'b0;
        step();
        check("t1_ack_pulse", {31'd0, entry_ack}, 32'd0);
        check("t1_gate2", {31'd0, gate_open}, 32'd1);
        gate_close(2);

        // Exit of a free spot.
        exit_req  = 1'b1;
        exit_spot = 3'd2;
        step();
        check("err_pulse", {31'd0, exit_err}, 32'd1);
        check("err_noack", {31'd0, exit_ack}, 32'd0);
        check("err_cap", {24'd0, new_capacity}, 32'h01);
        exit_req = 1'b0;
        step();
        check("err_clear", {31'd0, exit_err}, 32'd0);

        // Exit while the gate is open.
        entry_req = 1'b1;
        step();
        check("open_ack", {31'd0, entry_ack}, 32'd1);
        check("open_spot", {29'd0, entry_spot}, 32'd1);
        check("open_cap0", {24'd0, new_capacity}, 32'h03);
        entry_req = 1'b0;
        exit_req  = 1'b1;
        exit_spot = 3'd0;
        step();
        check("open_exit_ack", {31'd0, exit_ack}, 32'd1);
        check("open_exit_cap", {24'd0, new_capacity}, 32'h02);
        check("open_gate", {31'd0, gate_open}, 32'd1);
        exit_req = 1'b0;
        gate_close(2);

        do_entry(3'd0, 8'h03);

        // Same-edge exit of spot 0 and entry: spot 0 is not reused.
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_spot = 3'd0;
        step();
        check("same_ack", {31'd0, entry_ack}, 32'd1);
        check("same_spot", {29'd0, entry_spot}, 32'd2);
        check("same_exit_ack", {31'd0, exit_ack}, 32'd1);
        check("same_cap", {24'd0, new_capacity}, 32'h06);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        gate_close(3);

        // Build 8'b10010110.
        do_entry(3'd0, 8'h07);
        do_entry(3'd3, 8'h0F);
        do_entry(3'd4, 8'h1F);
        do_entry(3'd5, 8'h3F);
        do_entry(3'd6, 8'h7F);
        do_entry(3'd7, 8'hFF);
        do_exit(3'd0, 8'hFE);
        do_exit(3'd3, 8'hF6);
        do_exit(3'd5, 8'hD6);
        do_exit(3'd6, 8'h96);

        do_entry(3'd0, 8'h97);
        do_entry(3'd3, 8'h9F);
        do_entry(3'd5, 8'hBF);
        do_entry(3'd6, 8'hFF);

        // Full: entry_full follows entry_req.
        entry_req = 1'b1;
        step();
        check("full_set", {31'd0, entry_full}, 32'd1);
        entry_req = 1'b0;
        step();
        check("full_drop", {31'd0, entry_full}, 32'd0);

        // Full plus exit: allocation lands on the next edge.
        entry_req = 1'b1;
        step();
        check("full_a", {31'd0, entry_full}, 32'd1);
        check("full_noack", {31'd0, entry_ack}, 32'd0);
        step();
        check("full_b", {31'd0, entry_full}, 32'd1);
        exit_req  = 1'b1;
        exit_spot = 3'd5;
        step();
        check("fx_exit_ack", {31'd0, exit_ack}, 32'd1);
        check("fx_cap", {24'd0, new_capacity}, 32'hDF);
        check("fx_full", {31'd0, entry_full}, 32'd1);
        check("fx_noack", {31'd0, entry_ack}, 32'd0);
        exit_req = 1'b0;
        step();
        check("fx_ack", {31'd0, entry_ack}, 32'd1);
        check("fx_spot", {29'd0, entry_spot}, 32'd5);
        check("fx_cap2", {24'd0, new_capacity}, 32'hFF);
        check("fx_full_clr", {31'd0, entry_full}, 32'd0);
        entry_req = 1'b0;
        gate_close(3);

        // Top spot free only.
        do_exit(3'd7, 8'h7F);
`ifdef PARKING_RESERVED_SPOT_EN
        entry_vip = 1'b0;
        entry_req = 1'b1;
        step();
        check("rsv_full", {31'd0, entry_full}, 32'd1);
        check("rsv_noack", {31'd0, entry_ack}, 32'd0);
        entry_vip = 1'b1;
        step();
        check("rsv_vip_ack", {31'd0, entry_ack}, 32'd1);
        check("rsv_vip_spot", {29'd0, entry_spot}, 32'd7);
        check("rsv_vip_cap", {24'd0, new_capacity}, 32'hFF);
        entry_req = 1'b0;
        entry_vip = 1'b0;
        gate_close(3);
`else
        entry_vip = 1'b0;
        do_entry(3'd7, 8'hFF);
`endif

        // Asynchronous reset while the gate is open.
        do_exit(3'd2, 8'hFB);
        entry_req = 1'b1;
        step();
        check("ar_ack", {31'd0, entry_ack}, 32'd1);
        check("ar_spot", {29'd0, entry_spot}, 32'd2);
        entry_req = 1'b0;
        step();
        check("ar_gate_pre", {31'd0, gate_open}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gate", {31'd0, gate_open}, 32'd0);
        check("ar_cap", {24'd0, new_capacity}, 32'h00);
        check("ar_spot0", {29'd0, entry_spot}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("ar_gate_post", {31'd0, gate_open}, 32'd0);
        do_entry(3'd0, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parking_spot_allocator.md
Name: parking_spot_allocator

Overview:
- Producer side of the parking occupancy vector. Tracks cars entering and leaving, and assigns each entering car the lowest-numbered free spot.
- Maintains the registered 8-bit occupancy bitmap (bit i = 1 means spot i is taken). That bitmap drives new_capacity of the parking capacity counter.
- Also sequences the entry gate: the gate opens for a fixed time after each allocation.

Parameters:
- SPOTS, 8, number of spots; width of the occupancy vector.
- SPOT_W, 3, spot index width, equal to clog2(SPOTS).
- GATE_CYCLES, 4, cycles gate_open stays high after an allocation (must be 1 or more).

Ports:
- clk  input  1  system clock; one clock domain, all state on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- entry_req  input  1  level; a car is waiting at the entry gate.
- entry_vip  input  1  qualifies entry_req; used only when PARKING_RESERVED_SPOT_EN is defined.
- entry_ack  output  1  one-cycle pulse; a spot was allocated.
- entry_spot  output  SPOT_W  allocated spot index; valid while entry_ack=1, otherwise holds its last value.
- entry_full  output  1  registered; high while entry_req=1, the FSM is IDLE and no eligible spot is free.
- exit_req  input  1  one-cycle strobe; the car in exit_spot is leaving.
- exit_spot  input  SPOT_W  spot being vacated; sampled with exit_req.
- exit_ack  output  1  one-cycle pulse; the spot was freed.
- exit_err  output  1  one-cycle pulse; exit for an already-free spot or an index of SPOTS or more.
- gate_open  output  1  entry gate drive.
- new_capacity  output  SPOTS  registered occupancy bitmap.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - new_capacity=0, entry_spot=0.
  - entry_ack, entry_full, exit_ack, exit_err, gate_open all 0.
  - FSM in IDLE, gate counter 0.
  - Reset mid-gate: the gate closes immediately and all spots are freed.
- FSM states: IDLE, OPEN.
- IDLE:
  - entry_req=1 and an eligible free spot exists: at that edge set entry_ack=1, entry_spot=lowest free index, set that bit in new_capacity, gate_open=1, counter=GATE_CYCLES-1, move to OPEN.
  - entry_req=1 with no eligible free spot: entry_full=1 and stay in IDLE.
  - entry_full clears on the first edge where entry_req=0 or a spot is eligible.
- OPEN:
  - entry_req is ignored and entry_full=0.
  - Counter decrements each cycle. At counter=0, gate_open goes 0 and the FSM returns to IDLE on the same edge.
  - gate_open is therefore high for exactly GATE_CYCLES cycles.
- Entry handshake:
  - Latency from entry_req sampled in IDLE to entry_ack is one edge.
  - The requester must drop entry_req on seeing entry_ack.
  - If entry_req is still high on the return to IDLE, it is treated as a new car.
- Exit:
  - Accepted in any FSM state, independent of the gate.
  - On the edge sampling exit_req: if the bit is set, clear it and pulse exit_ack; otherwise pulse exit_err and leave new_capacity unchanged.
- Simultaneous entry and exit on the same edge:
  - The allocation search uses the pre-exit bitmap, so a spot being freed is never re-allocated on the same edge.
  - Full plus a simultaneous exit gives entry_full=1 for that cycle. The entry succeeds on the next edge if entry_req is still held.
  - Both updates apply to new_capacity on the same edge.
- Priority encoder: the lowest index wins. With all bits 1 there is no allocation.

Optional Feature:
- Macro: PARKING_RESERVED_SPOT_EN.
- Defined:
  - Spot SPOTS-1 is reserved and is allocated only when entry_vip=1 and all lower spots are full.
  - A non-VIP request gets entry_full=1 when spots 0..SPOTS-2 are taken, even if spot SPOTS-1 is free.
  - VIP requests still take the lowest free spot.
- Undefined: entry_vip is ignored and every spot is eligible.

Decomposition:
- Shared package parking_pkg holds:
  - localparams SPOTS_DEFAULT=8, SPOT_W_DEFAULT=3;
  - the gate FSM state typedef (IDLE, OPEN);
  - the function lowest_free(bitmap, mask) returning index plus found flag.
- One sub-module: parking_free_spot_encoder, a combinational priority encoder (bitmap, eligibility mask) -> (index, found). Reusable by the exit gate.

Test Plan:
- Reset, then entry_req held 1 cycle -> entry_ack next edge, entry_spot=0, new_capacity=8'b00000001, gate_open high 4 cycles.
- Start from new_capacity=8'b10010110, entry_req -> entry_spot=0, new_capacity=8'b10010111. Second car after the gate closes -> spot 3, new_capacity=8'b10011111.
- Start from 8'b11111111, entry_req held -> entry_full=1 and no ack. Then exit_req with spot 5 -> exit_ack, 8'b11011111, and on the next edge entry_ack with entry_spot=5.
- exit_req with spot 2 while 8'b00000001 -> exit_err pulse and bitmap unchanged. exit_req during OPEN for an occupied spot -> exit_ack and the bit cleared.
- Same edge: exit spot 0 plus entry_req with 8'b00000011 -> allocation gives spot 2, result 8'b00000110.
- With PARKING_RESERVED_SPOT_EN and 8'b01111111:
  - entry_vip=0 -> entry_full=1;
  - entry_vip=1 -> entry_spot=7, 8'b11111111.
- Assert rst_n low mid-OPEN -> gate_open=0 and new_capacity=0 immediately, with no clock edge needed.
